// File: rtl/spk_memory_ctrl.sv
// spk_memory_ctrl: spike-memory responder for the control unit's command bus.
// Holds two ping-pong spike banks and one spikeability memory. Spikes for the
// current timestep are read from bank[bank_sel] while the next timestep's
// spikes are written into bank[~bank_sel]. A swap pulse exchanges the roles.
// Optional macro SPKBLTY_BYPASS_EN: a same-cycle spikeability read and write to
// the same address returns the new word instead of the stored one.
module spk_memory_ctrl #(
  parameter int SPK_W     = 8,
  parameter int SPKBLTY_W = 8,
  parameter int DEPTH     = 512
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(DEPTH)-1:0]     cntrl_in_spk_read_addr,
  input  logic [$clog2(DEPTH)-1:0]     cntrl_ac_spk_read_addr,
  input  logic [2:0]                   cntrl_ac_spk_read_switch,
  input  logic [$clog2(DEPTH)-1:0]     cntrl_spk_write_addr,
  input  logic                         cntrl_spk_write_we,
  input  logic [SPK_W-1:0]             spk_write_data,
  input  logic                         cntrl_spk_bank_swap,
  input  logic [$clog2(DEPTH)-1:0]     cntrl_spkblty_read_addr,
  input  logic [$clog2(DEPTH)-1:0]     cntrl_spkblty_write_addr,
  input  logic                         cntrl_spkblty_write_we,
  input  logic [SPKBLTY_W-1:0]         spkblty_write_data,
  output logic [SPK_W-1:0]             in_spk_data,
  output logic                         ac_spk,
  output logic [SPKBLTY_W-1:0]         spkblty_data,
  output logic                         bank_sel,
  output logic [$clog2(DEPTH):0]       spk_write_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Write counter saturates at DEPTH so a runaway writer never wraps it.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CW'(DEPTH)) ? c : c + CW'(1);
  endfunction

  logic [SPK_W-1:0]     r_bank0   [DEPTH];
  logic [SPK_W-1:0]     r_bank1   [DEPTH];
  logic [SPKBLTY_W-1:0] r_spkblty [DEPTH];

  logic                 r_bank_sel;
  logic [CW-1:0]        r_write_count;
  logic [SPK_W-1:0]     r_in_spk_p1;
  logic                 r_ac_spk_p1;
  logic [SPKBLTY_W-1:0] r_spkblty_p1;

  logic [SPK_W-1:0]     w_in_word;
  logic [SPK_W-1:0]     w_ac_word;
  logic [SPK_W-1:0]     w_ac_shift;
  logic [SPKBLTY_W-1:0] w_spkblty_rd;

  // Read-bank selection; a shift of SPK_W or more naturally yields 0.
  assign w_in_word  = r_bank_sel ? r_bank1[cntrl_in_spk_read_addr] : r_bank0[cntrl_in_spk_read_addr];
  assign w_ac_word  = r_bank_sel ? r_bank1[cntrl_ac_spk_read_addr] : r_bank0[cntrl_ac_spk_read_addr];
  assign w_ac_shift = w_ac_word >> cntrl_ac_spk_read_switch;

`ifdef SPKBLTY_BYPASS_EN
  assign w_spkblty_rd = (cntrl_spkblty_write_we &&
                         (cntrl_spkblty_write_addr == cntrl_spkblty_read_addr))
                        ? spkblty_write_data : r_spkblty[cntrl_spkblty_read_addr];
`else
  assign w_spkblty_rd = r_spkblty[cntrl_spkblty_read_addr];
`endif

  // Memory writes: spikes go to the bank not currently being read; contents survive reset.
  always_ff @(posedge clk) begin
    if (cntrl_spk_write_we) begin
      if (r_bank_sel) r_bank0[cntrl_spk_write_addr] <= spk_write_data;
      else            r_bank1[cntrl_spk_write_addr] <= spk_write_data;
    end
    if (cntrl_spkblty_write_we)
      r_spkblty[cntrl_spkblty_write_addr] <= spkblty_write_data;
  end

  // Bank role and write count; a write coinciding with a swap is not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bank_sel    <= 1'b0;
      r_write_count <= '0;
    end else if (cntrl_spk_bank_swap) begin
      r_bank_sel    <= ~r_bank_sel;
      r_write_count <= '0;
    end else if (cntrl_spk_write_we) begin
      r_write_count <= sat_inc(r_write_count);
    end
  end

  // Read stage: one-cycle registered outputs for all three read ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_spk_p1  <= '0;
      r_ac_spk_p1  <= 1'b0;
      r_spkblty_p1 <= '0;
    end else begin
      r_in_spk_p1  <= w_in_word;
      r_ac_spk_p1  <= w_ac_shift[0];
      r_spkblty_p1 <= w_spkblty_rd;
    end
  end

  assign in_spk_data     = r_in_spk_p1;
  assign ac_spk          = r_ac_spk_p1;
  assign spkblty_data    = r_spkblty_p1;
  assign bank_sel        = r_bank_sel;
  assign spk_write_count = r_write_count;

endmodule

// File: doc/spk_memory_ctrl.md
# spk_memory_ctrl

- Responder end of the control unit's spike-memory command bus.
- Holds two ping-pong spike banks (512 × 8 b each) and one spikeability memory (512 × SPKBLTY_W).
- Executes the read/write addresses and write enables the control unit drives each cycle; returns registered data to the spike processor and accumulators.
- Swaps the spike banks at timestep boundaries, so spikes from timestep t are read while spikes for t+1 are written.

## Interface

Parameters:
- SPK_W, 8: spike word width (one bit per neuron lane).
- SPKBLTY_W, 8: spikeability word width.
- DEPTH, 512: entries per memory (addresses are 9 bits).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- cntrl_in_spk_read_addr  in  9  read-bank address for the input-spike read port.
- cntrl_ac_spk_read_addr  in  9  read-bank address for the accumulator spike read port.
- cntrl_ac_spk_read_switch  in  3  lane select within the accumulator spike word.
- cntrl_spk_write_addr  in  9  write-bank address.
- cntrl_spk_write_we  in  1  spike write enable.
- spk_write_data  in  SPK_W  spike word to write.
- cntrl_spk_bank_swap  in  1  single-cycle pulse marking the end of a timestep.
- cntrl_spkblty_read_addr  in  9  spikeability read address.
- cntrl_spkblty_write_addr  in  9  spikeability write address.
- cntrl_spkblty_write_we  in  1  spikeability write enable.
- spkblty_write_data  in  SPKBLTY_W  spikeability word to write.
- in_spk_data  out  SPK_W  registered input-spike word.
- ac_spk  out  1  registered selected spike bit.
- spkblty_data  out  SPKBLTY_W  registered spikeability word.
- bank_sel  out  1  current read bank; the write bank is ~bank_sel.
- spk_write_count  out  10  writes into the write bank since the last swap.

## Operation

- Two spike banks, B0 and B1.
  - Reads (both spike read ports) always access bank[bank_sel].
  - Writes always access bank[~bank_sel].
- Spike write: when cntrl_spk_write_we=1, store spk_write_data at bank[~bank_sel][cntrl_spk_write_addr].
- Bank swap: when cntrl_spk_bank_swap=1, bank_sel toggles and spk_write_count clears to 0.
  - A write in the same cycle as a swap lands in the pre-swap write bank.
  - That write is not counted.
- spk_write_count increments on each write in a non-swap cycle.
  - It saturates at 512 and never wraps.
  - Repeated writes to the same address count each time.
- in_spk_data ← bank[bank_sel][cntrl_in_spk_read_addr] every cycle (no enable).
- ac_spk ← bank[bank_sel][cntrl_ac_spk_read_addr][cntrl_ac_spk_read_switch].
  - The address and switch are sampled in the same cycle.
  - A switch value ≥ SPK_W returns 0.
- Spikeability: single bank.
  - spkblty_data ← mem[cntrl_spkblty_read_addr] every cycle.
  - Written when cntrl_spkblty_write_we=1.
- Reads and writes sample bank_sel as it stands before the edge, so a swap affects reads from the next cycle onward.
- Reset:
  - All outputs go to 0 (in_spk_data, ac_spk, spkblty_data, bank_sel, spk_write_count).
  - Memory contents are not cleared.
  - Asserting reset mid-timestep discards the swap state; the control unit rewrites both banks.

## Timing

- Read latency is 1 cycle: an address presented in cycle n gives data on the outputs after edge n+1.
- Write takes effect at the edge of cycle n and is visible to a read addressing it from cycle n+1.
- Spike read-after-write to the same address in the same cycle cannot collide, because reads and writes use different banks.
- Spikeability same-cycle read/write to the same address returns the old word (without SPKBLTY_BYPASS_EN).
- bank_sel and spk_write_count update at the edge on which cntrl_spk_bank_swap is sampled high.
- Back-to-back swap pulses toggle bank_sel on each cycle.
- No handshake: the block accepts one read per port and one write per memory every cycle, with no stall.

## Configuration

- SPKBLTY_BYPASS_EN defined:
  - A same-cycle spikeability read and write to the same address forwards spkblty_write_data to spkblty_data at the next edge (new data).
- SPKBLTY_BYPASS_EN undefined:
  - The same case returns the pre-write word (read-first).
- Spike banks are unaffected by the macro.

## Test plan

- Reset then idle → all outputs 0; bank_sel=0; spk_write_count=0.
- Write 0xA5 @addr 3, then pulse swap, then read in_spk @3 → in_spk_data=0xA5 one cycle after the address; bank_sel=1; count=0.
- With the read bank holding 0x04 @addr 7, set ac addr=7 with switch=2 → ac_spk=1; same address with switch=1 → ac_spk=0.
- 600 writes with no swap → spk_write_count reaches 512 and holds; write coincident with swap → count=0 and the data appears in the new read bank.
- Spikeability write 0x3C @10 and read @10 in the same cycle (old word 0x11):
  - with SPKBLTY_BYPASS_EN → 0x3C;
  - without it → 0x11, then 0x3C on the next read.
- Assert reset mid-timestep with bank_sel=1 and count=5 → immediately bank_sel=0 and count=0; pre-reset memory words still readable.
